// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam int MIN_DIV = 4;

    // Parity mode encoding, shared by receiver and transmitter
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop rx synchroniser with falling-edge pulse
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rx;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Preset to the idle level so leaving reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s    = sync_q;
    assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable UART receiver with error flags
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic              stop2,
    input  logic              clr_rdy,
    output logic              rdy,
    output logic [DATA_W-1:0] rx_data,
    output logic              par_err,
    output logic              frm_err,
    output logic              ovr_err
);

    localparam int BC_W = $clog2(DATA_W + 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    rx_state_t         state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_cap_q, div_cap_d;
    logic [1:0]        mode_q, mode_d;
    logic              stop2_q, stop2_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              stop_idx_q, stop_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              rdy_q, rdy_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_err_q, par_err_d;
    logic              frm_err_q, frm_err_d;
    logic              ovr_err_q, ovr_err_d;

    logic [DIV_W-1:0]  div_eff;
    logic [1:0]        mode_in;

    assign div_eff = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
    assign mode_in = !par_en ? PAR_NONE : (par_odd ? PAR_ODD : PAR_EVEN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_cap_d  = div_cap_q;
        mode_d     = mode_q;
        stop2_d    = stop2_q;
        bit_cnt_d  = bit_cnt_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        rdy_d      = rdy_q;
        data_d     = data_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        ovr_err_d  = ovr_err_q;

        if (clr_rdy) begin
            rdy_d     = 1'b0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
            ovr_err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_fall) begin
                    cnt_d     = div_eff >> 1;
                    div_cap_d = div_eff;
                    mode_d    = mode_in;
                    stop2_d   = stop2;
                    state_d   = ST_START;
                end
            end
            ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else begin
                    cnt_d = div_cap_q - DIV_W'(1);
                    if (state_q == ST_START) begin
                        bit_cnt_d = '0;
                        state_d   = rx_s ? ST_IDLE : ST_DATA;
                    end else if (state_q == ST_DATA) begin
                        shift_d = {rx_s, shift_q[DATA_W-1:1]};
                        if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                            perr_d     = 1'b0;
                            ferr_d     = 1'b0;
                            stop_idx_d = 1'b0;
                            state_d    = (mode_q != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BC_W'(1);
                        end
                    end else if (state_q == ST_PARITY) begin
                        perr_d  = (^shift_q) ^ rx_s ^ (mode_q == PAR_ODD);
                        state_d = ST_STOP;
                    end else begin
                        ferr_d = ferr_q | ~rx_s;
                        if (stop_idx_q == stop2_q) begin
                            // Delivery overrides a coincident clr_rdy
                            rdy_d     = 1'b1;
                            data_d    = shift_q;
                            par_err_d = perr_q;
                            frm_err_d = ferr_q | ~rx_s;
                            if (rdy_q && !clr_rdy) begin
                                ovr_err_d = 1'b1;
                            end
                            state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                        end else begin
                            stop_idx_d = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_cap_q  <= '0;
            mode_q     <= PAR_NONE;
            stop2_q    <= 1'b0;
            bit_cnt_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rdy_q      <= 1'b0;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cap_q  <= div_cap_d;
            mode_q     <= mode_d;
            stop2_q    <= stop2_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            rdy_q      <= rdy_d;
            data_q     <= data_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            ovr_err_q  <= ovr_err_d;
        end
    end

    assign rdy     = rdy_q;
    assign rx_data = data_q;
    assign par_err = par_err_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] baud_div;
    logic        par_en;
    logic        par_odd;
    logic        stop2;
    logic        clr_rdy;
    logic        rdy;
    logic [7:0]  rx_data;
    logic        par_err;
    logic        frm_err;
    logic        ovr_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rises = 0;
    int   rise_cyc = 0;
    logic rdy_prev = 1'b0;
    int   t_start = 0;
    int   lat = 0;
    int   r0;
    logic [9:0] exp_v;

    uart_rx_cfg #(.DATA_W(8), .DIV_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .baud_div (baud_div),
        .par_en   (par_en),
        .par_odd  (par_odd),
        .stop2    (stop2),
        .clr_rdy  (clr_rdy),
        .rdy      (rdy),
        .rx_data  (rx_data),
        .par_err  (par_err),
        .frm_err  (frm_err),
        .ovr_err  (ovr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdy === 1'b1 && rdy_prev !== 1'b1) begin
            rises    <= rises + 1;
            rise_cyc <= cyc;
        end
        rdy_prev <= rdy;
    end

    // Expected {par_err, frm_err, data} from the frame as it appears on the line
    function automatic logic [9:0] model(input logic [7:0] d, input bit pe, input bit po,
                                         input bit pbit, input bit s0, input bit s1, input bit two);
        int ones;
        bit pe_err;
        bit fe;
        ones   = $countones(d) + int'(pbit);
        pe_err = pe && ((ones % 2) != (po ? 1 : 0));
        fe     = !s0 || (two && !s1);
        return {pe_err, fe, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int eff);
        rx = b;
        repeat (eff) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int div, input bit pe, input bit po,
                              input bit pbit, input bit s0, input bit s1, input bit two);
        int eff;
        eff = (div < 4) ? 4 : div;
        @(negedge clk);
        baud_div = 16'(div);
        par_en   = pe;
        par_odd  = po;
        stop2    = two;
        t_start  = cyc + 1;
        drive_bit(1'b0, eff);
        for (int i = 0; i < 8; i++) drive_bit(d[i], eff);
        if (pe) drive_bit(pbit, eff);
        drive_bit(s0, eff);
        if (two) drive_bit(s1, eff);
        rx = 1'b1;
    endtask

    task automatic wait_rdy(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rdy === 1'b1) break;
            @(negedge clk);
        end
        check({tag, "_rdy"}, rdy, 1);
    endtask

    task automatic check_frame(input string tag, input logic [9:0] e, input logic e_ovr);
        check({tag, "_data"}, rx_data, e[7:0]);
        check({tag, "_par_err"}, par_err, e[9]);
        check({tag, "_frm_err"}, frm_err, e[8]);
        check({tag, "_ovr_err"}, ovr_err, e_ovr);
    endtask

    task automatic clr_pulse(input string tag);
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        check({tag, "_clr_rdy"}, rdy, 0);
        check({tag, "_clr_flags"}, {par_err, frm_err, ovr_err}, 3'b000);
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        clr_rdy  = 1'b0;
        baud_div = 16'd16;
        par_en   = 1'b0;
        par_odd  = 1'b0;
        stop2    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rdy", rdy, 0);
        check("reset_data", rx_data, 0);
        check("reset_flags", {par_err, frm_err, ovr_err}, 3'b000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5 with latency window
        send_frame(8'hA5, 16, 0, 0, 0, 1, 1, 0);
        wait_rdy("t1", 200);
        @(negedge clk);
        lat = rise_cyc - t_start;
        check("t1_latency_ok", (lat >= 149 && lat <= 155), 1);
        check_frame("t1", model(8'hA5, 0, 0, 0, 1, 1, 0), 1'b0);
        clr_pulse("t1");

        // Even parity, bad then good parity bit
        send_frame(8'h03, 16, 1, 0, 1, 1, 1, 0);
        wait_rdy("t2a", 200);
        check_frame("t2a", model(8'h03, 1, 0, 1, 1, 1, 0), 1'b0);
        clr_pulse("t2a");
        send_frame(8'h03, 16, 1, 0, 0, 1, 1, 0);
        wait_rdy("t2b", 200);
        check_frame("t2b", model(8'h03, 1, 0, 0, 1, 1, 0), 1'b0);
        clr_pulse("t2b");

        // Line break: one frame with frm_err, then silence until the line recovers
        r0 = rises;
        @(negedge clk);
        baud_div = 16'd16; par_en = 1'b0; stop2 = 1'b0;
        rx = 1'b0;
        repeat (10 * 16) @(negedge clk);
        check("t3_break_rdy", rdy, 1);
        check_frame("t3_break", model(8'h00, 0, 0, 0, 0, 1, 0), 1'b0);
        clr_pulse("t3");
        repeat (20 * 16) @(negedge clk);
        check("t3_single_pulse", rises - r0, 1);
        check("t3_no_rdy", rdy, 0);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        send_frame(8'h3C, 16, 0, 0, 0, 1, 1, 0);
        wait_rdy("t3_after", 200);
        check_frame("t3_after", model(8'h3C, 0, 0, 0, 1, 1, 0), 1'b0);
        check("t3_pulses", rises - r0, 2);
        clr_pulse("t3_after");

        // Short glitch is rejected as a false start
        r0 = rises;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        check("t4_glitch_rdy", rdy, 0);
        check("t4_glitch_rises", rises - r0, 0);
        check("t4_glitch_flags", {par_err, frm_err, ovr_err}, 3'b000);
        send_frame(8'h5A, 16, 0, 0, 0, 1, 1, 0);
        wait_rdy("t4", 200);
        check_frame("t4", model(8'h5A, 0, 0, 0, 1, 1, 0), 1'b0);
        clr_pulse("t4");

        // Back-to-back with two stop bits, no acknowledge in between
        send_frame(8'h11, 16, 0, 0, 0, 1, 1, 1);
        send_frame(8'h22, 16, 0, 0, 0, 1, 1, 1);
        wait_rdy("t5", 200);
        check_frame("t5", model(8'h22, 0, 0, 0, 1, 1, 1), 1'b1);
        clr_pulse("t5");

        // clr_rdy landing on the completing edge: new frame wins, no overrun
        send_frame(8'h77, 16, 0, 0, 0, 1, 1, 0);
        wait_rdy("t5b_first", 200);
        fork
            send_frame(8'h99, 16, 0, 0, 0, 1, 1, 0);
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 2000; i++) begin
                    if (cyc == t_start + lat - 1) break;
                    @(negedge clk);
                end
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
            end
        join
        wait_rdy("t5b", 200);
        check_frame("t5b", model(8'h99, 0, 0, 0, 1, 1, 0), 1'b0);
        clr_pulse("t5b");

        // Reset in the middle of data bit 4 with a frame pending
        send_frame(8'h44, 16, 0, 0, 0, 1, 1, 0);
        wait_rdy("t6_pre", 200);
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_rdy", rdy, 0);
        check("t6_rst_data", rx_data, 0);
        check("t6_rst_flags", {par_err, frm_err, ovr_err}, 3'b000);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'hC3, 10, 0, 0, 0, 1, 1, 0);
        wait_rdy("t6", 200);
        check_frame("t6", model(8'hC3, 0, 0, 0, 1, 1, 0), 1'b0);
        clr_pulse("t6");

        // Random configurations, including divisors below the minimum
        for (int k = 0; k < 12; k++) begin
            logic [7:0] d;
            int  div;
            bit  pe, po, pbit, two, s0, s1;
            d    = 8'($urandom);
            div  = $urandom_range(0, 12);
            pe   = 1'($urandom);
            po   = 1'($urandom);
            pbit = 1'($urandom);
            two  = 1'($urandom);
            s0   = ($urandom_range(0, 3) != 0);
            s1   = ($urandom_range(0, 3) != 0);
            send_frame(d, div, pe, po, pbit, s0, s1, two);
            wait_rdy($sformatf("rnd%0d", k), 100);
            exp_v = model(d, pe, po, pbit, s0, s1, two);
            check_frame($sformatf("rnd%0d", k), exp_v, 1'b0);
            clr_pulse($sformatf("rnd%0d", k));
            repeat (32) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver. Successor to the team's fixed 8N1 receiver.
Adds programmable baud divisor, optional even/odd parity, 1 or 2 stop bits, false-start rejection, and parity/framing/overrun error flags.
Sits between the board RX pin and the register/SPART front end. Same rdy/clr_rdy consumer handshake as the existing receiver.

Parameters:
DATA_W, 8, data bits per frame, legal range 5..9, LSB received first
DIV_W, 16, width of baud_div input
Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
rx  in  1  asynchronous serial input, idles high
baud_div  in  DIV_W  clocks per bit; values below 4 are treated as 4
par_en  in  1  1 = a parity bit follows the data bits
par_odd  in  1  1 = odd parity, 0 = even parity; ignored when par_en=0
stop2  in  1  1 = two stop bits, 0 = one stop bit
clr_rdy  in  1  consumer acknowledge; clears rdy and all error flags
rdy  out  1  frame available in rx_data
rx_data  out  DATA_W  last received data word
par_err  out  1  parity mismatch on the last frame
frm_err  out  1  a stop bit sampled low on the last frame
ovr_err  out  1  a frame completed while rdy was still set

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: while rst=1 at a clk edge, all outputs go to 0 and the FSM goes to IDLE. Synchroniser flops preset to 1. Reset mid-frame discards the partial frame.
- rx passes through a 2-flop synchroniser (rx_s). Start detection uses the falling edge of rx_s: previous value 1, current value 0.
- Configuration (baud_div, par_en, par_odd, stop2) is captured at start detection. Changes mid-frame have no effect until the next frame.
- Baud counter, DIV_W bits, counts down to 0. On reaching 0 it samples rx_s and reloads to div_cap-1. This gives one sample per div_cap cycles, centred in each bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on a falling edge, load counter with div_cap>>1 and go to START.
- START: sample at count 0. If rx_s=1, it is a false start: go to IDLE with no flags and no rdy. Otherwise go to DATA with bit_cnt=0.
- DATA: shift each sample into the MSB of the shift register (LSB-first line order). After DATA_W samples, go to PARITY if par_en is set, else to STOP.
- PARITY: sample once. The error is the XOR of the data bits, the parity bit and par_odd.
- STOP: sample 1 or 2 bits (stop2). Any low stop sample marks a framing error. After the last stop sample:
  - rx_data <= shift register; rdy <= 1.
  - par_err and frm_err take this frame's values.
  - ovr_err <= 1 if rdy was already 1, else unchanged.
- After STOP: go to IDLE if the last stop sample was 1, else to WAIT_HIGH. WAIT_HIGH holds until rx_s=1, then goes to IDLE. A line break therefore yields exactly one frame with frm_err.
- rdy latency: rdy rises on the clk edge that ends the cycle in which the final stop-bit count reaches 0.
- Frames with errors are still delivered; the flags qualify the data.
- clr_rdy clears rdy, par_err, frm_err and ovr_err. If clr_rdy coincides with a frame completing, the set wins: rdy=1 with the new frame's flags, and ovr_err is not set.
- Back-to-back frames are supported: after a good stop bit the FSM is in IDLE in time for the next start edge.
- bit_cnt width is $clog2(DATA_W+1). No counter may wrap mid-frame.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (6 states).
  - MIN_DIV = 4.
  - Parity-mode localparams, shared with a future uart_tx_cfg.
- Sub-module uart_rx_sync: 2-flop synchroniser with preset-to-1 on rst, falling-edge pulse output.
- FSM, counters and flag registers stay in uart_rx_cfg.

Test Plan:
1. 8N1, baud_div=16, send 0xA5 → rdy=1 within 152±3 cycles of the rx falling edge; rx_data=0xA5; all error flags 0.
2. Even parity, baud_div=16, send 0x03 with parity bit 1 → rdy=1, rx_data=0x03, par_err=1. Repeat with parity bit 0 → par_err=0.
3. Stop bit driven low, then rx held low for 20 bit times → exactly one rdy pulse with frm_err=1. No further rdy until rx returns high and a new frame is sent.
4. rx glitch low for 4 cycles (baud_div=16) → no rdy, no flags, FSM back in IDLE. A following valid 0x5A is received correctly.
5. Two back-to-back frames 0x11 then 0x22 with no clr_rdy, stop2=1 → rx_data=0x22 and ovr_err=1. Then clr_rdy → rdy, ovr_err, par_err and frm_err all read 0.
6. Assert rst during data bit 4 of a frame → all outputs 0 the next cycle. The next frame 0xC3 (baud_div=10) is received correctly.
